jpeg2bmp_mul_arbiter: RTL and testbench
=======================================

Name: jpeg2bmp_mul_arbiter

Overview:
Shares one pipelined unsigned-16 × signed-32 multiplier among NUM_REQ requesters in the jpeg2bmp datapath, such as the IDCT, colour-conversion and dequant loops.
- Round-robin arbitration with a valid/ready handshake on each request port.
- Each result carries an owner tag and returns only to the requester that issued it.
- Replaces per-loop multiplier instances to cut DSP usage.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
A_WIDTH, 16, operand A width, zero-extended (unsigned)
B_WIDTH, 32, operand B width, signed
P_WIDTH, 32, product width; the two's-complement product is truncated to its low P_WIDTH bits
MUL_LATENCY, 2, pipeline stages from accept to rsp_valid (>=1)

Ports:
clk  in  1  clock; all state changes on the rising edge
reset  in  1  asynchronous, active-high reset
req_valid  in  NUM_REQ  request valid, one bit per requester
req_ready  out  NUM_REQ  grant/accept, at most one bit high
req_a  in  NUM_REQ*A_WIDTH  operand A; requester i uses bits [i*A_WIDTH +: A_WIDTH]
req_b  in  NUM_REQ*B_WIDTH  operand B; requester i uses bits [i*B_WIDTH +: B_WIDTH]
rsp_valid  out  NUM_REQ  one-hot result valid, indexed by owner
rsp_ready  in  NUM_REQ  result accept, per requester
rsp_data  out  P_WIDTH  product for the owner flagged by rsp_valid

Behaviour:
- Reset (async, active-high):
  - all pipeline valid bits clear; rsp_valid=0, rsp_data=0, req_ready=0;
  - round-robin pointer = NUM_REQ-1, so requester 0 has first priority.
- Pipeline: MUL_LATENCY stages, each holding valid, owner index and data.
  - Stage 1 registers the operands.
  - Stage MUL_LATENCY holds the product: $signed({1'b0,a}) * $signed(b), low P_WIDTH bits.
- Advance enable: ce = !out_valid || rsp_ready[out_owner].
  - When ce=0 the whole pipeline freezes (global stall, no bubble collapse).
- Grant (combinational):
  - req_ready[i]=1 only if ce=1, req_valid[i]=1, and i is the first set req_valid bit scanning from pointer+1 upward, wrapping.
  - No valid requester or ce=0 → req_ready=0.
  - A stage-1 bubble is inserted when nobody is granted.
- Accept: a transfer happens on an edge where req_valid[i] & req_ready[i].
  - The pointer updates to i on that edge; otherwise it holds.
- Requester obligation: hold req_valid and operands stable until accepted. The block never drops a pending request.
- Latency: accept at edge T → rsp_valid[owner]=1 after edge T+MUL_LATENCY-1, i.e. it is visible in the cycle following that edge, when no stall occurs. Each stall cycle adds one.
- Response:
  - rsp_valid[out_owner]=out_valid, all other bits 0.
  - rsp_data holds the stored product and is stable while rsp_valid=1 and rsp_ready=0.
  - After rsp_valid deasserts, rsp_data holds its last value.
- Throughput: one accept per cycle when no stall. A response pop and a new accept may occur on the same edge.
- Fairness: with all requesters continuously valid, grants cycle 0,1,2,3,0,… Worst-case wait is NUM_REQ-1 grants.
- Same requester, back-to-back accepts: allowed if it is the only valid requester. Results return in issue order.
- Reset mid-operation: in-flight products are discarded, no rsp_valid is produced for them, and the pointer reinitialises.
- Invalid owner or X: cannot occur; the owner tag is registered only alongside valid=1.

Optional Feature:
JPEG2BMP_MUL_ARB_STATS_EN
- Defined: adds output ports stat_busy[31:0] and stat_stall[31:0].
  - stat_busy counts cycles with any stage valid.
  - stat_stall counts cycles with ce=0.
  - Both saturate at 0xFFFFFFFF and clear on reset.
- Undefined: ports and counters are absent; the functional behaviour is identical.

Test Plan:
1. Single request: req 0 with a=3, b=-5, rsp_ready=1 → rsp_valid=4'b0001 two cycles after accept, rsp_data=0xFFFFFFF1.
2. Width/sign: a=0xFFFF, b=2 → 0x0001FFFE; a=0x8000, b=0x00020000 → 0x00000000 (truncation).
3. Round-robin: req_valid=4'b1111 held for 8 accepts → grant order 0,1,2,3,0,1,2,3; each rsp_valid one-hot matches the issuing owner.
4. Back-pressure: requester 2 holds rsp_ready=0 for 5 cycles while others request → req_ready=0 and rsp_data stable during the stall. On release, results drain in order with no loss or duplication.
5. Async reset asserted mid-burst with 2 products in flight → outputs go to 0 immediately without a clock edge. After release, no stale rsp_valid appears and the first grant goes to requester 0.
6. With JPEG2BMP_MUL_ARB_STATS_EN: run test 4 → stat_stall=5, and stat_busy equals the count of cycles with any stage valid.

Source files
------------

// File: rtl/jpeg2bmp_mul_arbiter.sv
// Round-robin arbiter that shares one pipelined unsigned(A) x signed(B) multiplier among NUM_REQ requesters.
// Optional build macro JPEG2BMP_MUL_ARB_STATS_EN adds stat_busy/stat_stall saturating counters.
module jpeg2bmp_mul_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int A_WIDTH     = 16,
    parameter int B_WIDTH     = 32,
    parameter int P_WIDTH     = 32,
    parameter int MUL_LATENCY = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*A_WIDTH-1:0] req_a,
    input  logic [NUM_REQ*B_WIDTH-1:0] req_b,
    output logic [NUM_REQ-1:0]         rsp_valid,
    input  logic [NUM_REQ-1:0]         rsp_ready,
    output logic [P_WIDTH-1:0]         rsp_data
`ifdef JPEG2BMP_MUL_ARB_STATS_EN
    ,
    output logic [31:0]                stat_busy,
    output logic [31:0]                stat_stall
`endif
);

    localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int FULL_W = A_WIDTH + B_WIDTH + 1;
    localparam int OPS    = (MUL_LATENCY > 1) ? MUL_LATENCY - 1 : 1;

    // Zero-extended A times sign-extended B, truncated to the product width.
    function automatic logic [P_WIDTH-1:0] mul_trunc(input logic [A_WIDTH-1:0] a,
                                                     input logic [B_WIDTH-1:0] b);
        logic signed [FULL_W-1:0] a_ext;
        logic signed [FULL_W-1:0] b_ext;
        logic signed [FULL_W-1:0] full_v;
        a_ext  = $signed({{(B_WIDTH + 1){1'b0}}, a});
        b_ext  = $signed({{(A_WIDTH + 1){b[B_WIDTH-1]}}, b});
        full_v = a_ext * b_ext;
        return full_v[P_WIDTH-1:0];
    endfunction

    logic [MUL_LATENCY-1:0] vld_r;
    logic [IDX_W-1:0]       own_r [MUL_LATENCY];
    logic [A_WIDTH-1:0]     opa_r [OPS];
    logic [B_WIDTH-1:0]     opb_r [OPS];
    logic [P_WIDTH-1:0]     prod_r;
    logic [IDX_W-1:0]       ptr_r;

    logic                   ce_s;
    logic                   gnt_any_s;
    logic [IDX_W-1:0]       gnt_idx_s;
    logic                   accept_s;
    logic [A_WIDTH-1:0]     sel_a_s;
    logic [B_WIDTH-1:0]     sel_b_s;

    // Whole pipeline freezes while the output stage is held by its owner.
    always_comb begin
        ce_s     = !vld_r[MUL_LATENCY-1] || rsp_ready[own_r[MUL_LATENCY-1]];
        accept_s = ce_s && gnt_any_s && !reset;
    end

    // Round-robin scan from pointer+1 upward with wrap, plus operand selection.
    always_comb begin
        gnt_any_s = 1'b0;
        gnt_idx_s = '0;
        sel_a_s   = '0;
        sel_b_s   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            int  idx;
            logic hit;
            idx       = (int'(ptr_r) + k) % NUM_REQ;
            hit       = !gnt_any_s && req_valid[idx];
            gnt_idx_s = hit ? IDX_W'(idx) : gnt_idx_s;
            gnt_any_s = gnt_any_s | hit;
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            sel_a_s = (gnt_idx_s == IDX_W'(i)) ? req_a[i*A_WIDTH +: A_WIDTH] : sel_a_s;
            sel_b_s = (gnt_idx_s == IDX_W'(i)) ? req_b[i*B_WIDTH +: B_WIDTH] : sel_b_s;
        end
        req_ready = '0;
        if (accept_s) begin
            req_ready[gnt_idx_s] = 1'b1;
        end else begin
            req_ready = '0;
        end
    end

    // Response port: one-hot valid indexed by the output-stage owner.
    always_comb begin
        rsp_valid                          = '0;
        rsp_valid[own_r[MUL_LATENCY-1]]    = vld_r[MUL_LATENCY-1];
        rsp_data                           = prod_r;
    end

    // Valid/owner/operand pipeline and round-robin pointer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_r <= '0;
            ptr_r <= IDX_W'(NUM_REQ - 1);
            for (int s = 0; s < MUL_LATENCY; s++) begin
                own_r[s] <= '0;
            end
            for (int s = 0; s < OPS; s++) begin
                opa_r[s] <= '0;
                opb_r[s] <= '0;
            end
        end else if (ce_s) begin
            vld_r[0] <= accept_s;
            if (accept_s) begin
                own_r[0] <= gnt_idx_s;
                opa_r[0] <= sel_a_s;
                opb_r[0] <= sel_b_s;
                ptr_r    <= gnt_idx_s;
            end
            for (int s = 1; s < MUL_LATENCY; s++) begin
                vld_r[s] <= vld_r[s-1];
                if (vld_r[s-1]) begin
                    own_r[s] <= own_r[s-1];
                end
            end
            for (int s = 1; s < OPS; s++) begin
                if (vld_r[s-1]) begin
                    opa_r[s] <= opa_r[s-1];
                    opb_r[s] <= opb_r[s-1];
                end
            end
        end
    end

    generate
        if (MUL_LATENCY == 1) begin : g_lat1
            // Single-stage build multiplies straight from the granted operands.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    prod_r <= '0;
                end else if (ce_s && accept_s) begin
                    prod_r <= mul_trunc(sel_a_s, sel_b_s);
                end
            end
        end else begin : g_latn
            // Product register only loads alongside a valid so rsp_data keeps its last value.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    prod_r <= '0;
                end else if (ce_s && vld_r[MUL_LATENCY-2]) begin
                    prod_r <= mul_trunc(opa_r[MUL_LATENCY-2], opb_r[MUL_LATENCY-2]);
                end
            end
        end
    endgenerate

`ifdef JPEG2BMP_MUL_ARB_STATS_EN
    logic [31:0] busy_r;
    logic [31:0] stall_r;

    // Saturating occupancy and stall cycle counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_r  <= 32'd0;
            stall_r <= 32'd0;
        end else begin
            if ((|vld_r) && (busy_r != 32'hFFFF_FFFF)) begin
                busy_r <= busy_r + 32'd1;
            end
            if (!ce_s && (stall_r != 32'hFFFF_FFFF)) begin
                stall_r <= stall_r + 32'd1;
            end
        end
    end

    assign stat_busy  = busy_r;
    assign stat_stall = stall_r;
`endif

endmodule

// File: tb/tb_jpeg2bmp_mul_arbiter.sv
// Scoreboard bench for jpeg2bmp_mul_arbiter: accepts push reference products, a negedge monitor pops and compares.
module tb_jpeg2bmp_mul_arbiter;
    localparam int N = 4, AW = 16, BW = 32, PW = 32, LAT = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  req_valid, req_ready, rsp_valid, rsp_ready;
    logic [N*AW-1:0] req_a;
    logic [N*BW-1:0] req_b;
    logic [PW-1:0] rsp_data;
`ifdef JPEG2BMP_MUL_ARB_STATS_EN
    logic [31:0]   stat_busy, stat_stall;
`endif

    jpeg2bmp_mul_arbiter #(.NUM_REQ(N), .A_WIDTH(AW), .B_WIDTH(BW), .P_WIDTH(PW), .MUL_LATENCY(LAT)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data)
`ifdef JPEG2BMP_MUL_ARB_STATS_EN
        , .stat_busy(stat_busy), .stat_stall(stat_stall)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: mathematical product of unsigned a and signed b, low 32 bits.
    function automatic logic [31:0] ref_mul(input logic [15:0] a, input logic [31:0] b);
        longint      p;
        logic [63:0] pv;
        p  = longint'(a) * longint'($signed(b));
        pv = p;
        return pv[31:0];
    endfunction

    function automatic int rr_pick(input logic [N-1:0] v, input int last);
        for (int k = 1; k <= N; k++) begin
            if (v[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    typedef struct {int own; logic [31:0] prod;} exp_t;
    exp_t        q[$];
    int          grants[$];
    int          last_g = N - 1;
    logic [N-1:0] acc_n = '0;
    bit          hold_v = 1'b0;
    logic [31:0] hold_d;
    logic [N-1:0] hold_o;
    int          idle_cnt = 0;
    int          mode = 0;

    // Monitor: grant fairness, response ordering/data, hold stability, bounded latency.
    always @(negedge clk) begin
        if (reset) begin
            q.delete();
            last_g   = N - 1;
            hold_v   = 1'b0;
            acc_n    = '0;
            idle_cnt = 0;
        end else begin
            logic stall;
            acc_n = req_valid & req_ready;
            stall = (rsp_valid & ~rsp_ready) != '0;
            if (hold_v) begin
                chk("rsp_hold_data", rsp_data, hold_d);
                chk("rsp_hold_owner", rsp_valid, hold_o);
            end
            if (stall) chk("stall_no_grant", req_ready, 0);
            else if (req_valid != '0) begin
                int g;
                g = rr_pick(req_valid, last_g);
                chk("rr_grant", req_ready, 64'd1 << g);
            end
            if (rsp_valid != '0) begin
                idle_cnt = 0;
                if (q.size() == 0) chk("stale_rsp", rsp_valid, 0);
                else begin
                    chk("rsp_owner", rsp_valid, 64'd1 << q[0].own);
                    chk("rsp_data", rsp_data, q[0].prod);
                    if ((rsp_valid & rsp_ready) != '0) void'(q.pop_front());
                end
            end else if (q.size() > 0) begin
                idle_cnt++;
                if (idle_cnt > LAT + 1) begin
                    chk("rsp_timeout", idle_cnt, 0);
                    idle_cnt = 0;
                end
            end
            if (acc_n != '0) begin
                int g;
                exp_t e;
                g = rr_pick(acc_n, -1);
                e.own  = g;
                e.prod = ref_mul(req_a[g*AW +: AW], req_b[g*BW +: BW]);
                q.push_back(e);
                grants.push_back(g);
                last_g = g;
            end
            hold_v = stall;
            hold_d = rsp_data;
            hold_o = rsp_valid;
        end
    end

    task automatic set_req(input int i, input logic [15:0] a, input logic [31:0] b);
        req_a[i*AW +: AW] = a;
        req_b[i*BW +: BW] = b;
    endtask

    task automatic rand_req(input int i);
        logic [15:0] a;
        logic [31:0] b;
        a = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
        b = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
        set_req(i, a, b);
    endtask

    // One clock: advance past the edge, then let the auto driver update requests.
    task automatic tick();
        @(posedge clk);
        #1;
        if (mode != 0) begin
            for (int i = 0; i < N; i++) begin
                if (acc_n[i] || !req_valid[i]) begin
                    if (mode == 1) begin
                        rand_req(i);
                        req_valid[i] = 1'b1;
                    end else if ($urandom_range(0, 2) != 0) begin
                        rand_req(i);
                        req_valid[i] = 1'b1;
                    end else begin
                        req_valid[i] = 1'b0;
                    end
                end
            end
            if (mode == 2) rsp_ready = N'($urandom);
        end
    endtask

    task automatic do_reset();
        mode      = 0;
        reset     = 1'b1;
        req_valid = '0;
        rsp_ready = '1;
        @(negedge clk);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_req_ready", req_ready, 0);
        chk("reset_rsp_data", rsp_data, 0);
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic single(input int i, input logic [15:0] a, input logic [31:0] b, input logic [31:0] exp);
        set_req(i, a, b);
        req_valid    = '0;
        req_valid[i] = 1'b1;
        @(negedge clk);
        chk("single_ready", req_ready, 64'd1 << i);
        tick();
        req_valid = '0;
        @(negedge clk);
        chk("single_not_early", rsp_valid, 0);
        @(negedge clk);
        chk("single_rsp_valid", rsp_valid, 64'd1 << i);
        chk("single_rsp_data", rsp_data, exp);
        tick();
    endtask

    initial begin
        bit seen;
        logic [31:0] d0;
`ifdef JPEG2BMP_MUL_ARB_STATS_EN
        logic [31:0] st0;
`endif
        reset = 1'b0; req_valid = '0; rsp_ready = '1; req_a = '0; req_b = '0;
        #2;
        do_reset();

        // Single requests, sign extension and truncation corners.
        single(0, 16'd3, 32'hFFFF_FFFB, 32'hFFFF_FFF1);
        single(0, 16'hFFFF, 32'd2, 32'h0001_FFFE);
        single(0, 16'h8000, 32'h0002_0000, 32'h0000_0000);
        single(3, 16'hFFFF, 32'h8000_0000, 32'h8000_0000);

        // Round-robin with everyone continuously valid.
        do_reset();
        grants.delete();
        for (int i = 0; i < N; i++) rand_req(i);
        req_valid = '1;
        mode = 1;
        for (int c = 0; c < 40 && grants.size() < 8; c++) tick();
        chk("rr_count", grants.size() >= 8, 1);
        for (int k = 0; k < 8 && k < grants.size(); k++) chk("rr_order", grants[k], k % N);

        // Back-pressure from requester 2 for five cycles.
        rsp_ready = 4'b1011;
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (rsp_valid[2]) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        chk("bp_seen", seen, 1);
        d0 = rsp_data;
`ifdef JPEG2BMP_MUL_ARB_STATS_EN
        st0 = stat_stall;
`endif
        for (int k = 0; k < 5; k++) begin
            chk("bp_no_grant", req_ready, 0);
            chk("bp_data_stable", rsp_data, d0);
            if (k < 4) begin
                tick();
                @(negedge clk);
            end
        end
        tick();
        rsp_ready = '1;
        @(negedge clk);
`ifdef JPEG2BMP_MUL_ARB_STATS_EN
        chk("stat_stall_delta", stat_stall - st0, 5);
`endif
        for (int c = 0; c < 20; c++) tick();
        mode = 0;
        req_valid = '0;
        for (int c = 0; c < 20 && q.size() > 0; c++) tick();
        @(negedge clk);
        chk("bp_drained", q.size(), 0);

        // Asynchronous reset with two products in flight.
        do_reset();
        set_req(1, 16'd7, 32'd9);
        set_req(2, 16'd11, 32'd13);
        req_valid = 4'b0110;
        tick();
        req_valid = 4'b0100;
        tick();
        set_req(0, 16'd5, 32'd6);
        set_req(3, 16'd2, 32'd4);
        req_valid = 4'b1111;
        chk("t5_inflight", rsp_valid, 4'b0010);
        #2 reset = 1'b1;
        #1;
        chk("t5_async_rsp_valid", rsp_valid, 0);
        chk("t5_async_rsp_data", rsp_data, 0);
        chk("t5_async_req_ready", req_ready, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("t5_first_grant", req_ready, 4'b0001);
        mode = 1;
        for (int c = 0; c < 12; c++) tick();

        // Randomized traffic with random back-pressure.
        mode = 2;
        for (int c = 0; c < 800; c++) tick();
        mode = 0;
        req_valid = '0;
        rsp_ready = '1;
        for (int c = 0; c < 20 && q.size() > 0; c++) tick();
        @(negedge clk);
        chk("final_drained", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
